// File: rtl/dds_spi_master.sv
// Serial loader for the DDS core: takes a frequency or phase-shift word over a valid/ready port
// and shifts it out MSB first on spi_clk/spi_data, framed by freq_cs or phaseshift_cs.
module dds_spi_master #(
  parameter int ACC_LENGTH   = 16,
  parameter int PHASE_LENGTH = 8,
  parameter int CLK_DIV      = 4
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic                  cmd_sel,
  input  logic [ACC_LENGTH-1:0] cmd_data,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_clk,
  output logic                  spi_data,
  output logic                  freq_cs,
  output logic                  phaseshift_cs,
  output logic [2:0]            dbg_state_o
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(ACC_LENGTH + 1);
  localparam logic [HW-1:0] H_LAST  = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] N_FREQ  = BW'(ACC_LENGTH);
  localparam logic [BW-1:0] N_PHASE = BW'(PHASE_LENGTH);

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready are both high;
  // cmd_ready is high only in IDLE, and cmd_valid seen in any other state is dropped, not queued.
  // RELEASE has no dwell: it is the LOW->GAP transition that drops CS and pulses done.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [ACC_LENGTH-1:0] sreg_q, sreg_d;
  logic                  sclk_q, sclk_d;
  logic                  sdata_q, sdata_d;
  logic                  fcs_q, fcs_d;
  logic                  pcs_q, pcs_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic [ACC_LENGTH-1:0] load_word;
  logic                  hcnt_last;

  // Phase words are left-aligned so both word types shift out of the same MSB position.
  assign load_word = cmd_sel ? (ACC_LENGTH'(cmd_data[PHASE_LENGTH-1:0]) << (ACC_LENGTH - PHASE_LENGTH))
                             : cmd_data;
  assign hcnt_last = (hcnt_q == H_LAST);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bits_d  = bits_q;
    sreg_d  = sreg_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    fcs_d   = fcs_q;
    pcs_d   = pcs_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      hcnt_d = hcnt_last ? '0 : hcnt_q + HW'(1);
    end
    case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        if (cmd_valid) begin
          state_d = S_SETUP;
          sreg_d  = load_word;
          sdata_d = load_word[ACC_LENGTH-1];
          sclk_d  = 1'b0;
          fcs_d   = ~cmd_sel;
          pcs_d   = cmd_sel;
          bits_d  = cmd_sel ? N_PHASE : N_FREQ;
        end
      end
      S_SETUP: begin
        if (hcnt_last) begin
          state_d = S_HIGH;
          sclk_d  = 1'b1;
        end
      end
      S_HIGH: begin
        if (hcnt_last) begin
          state_d = S_LOW;
          sclk_d  = 1'b0;
          bits_d  = bits_q - BW'(1);
          // bits_q counts the bit currently on the line; only shift if another one follows
          if (bits_q > BW'(1)) begin
            sreg_d  = sreg_q << 1;
            sdata_d = sreg_q[ACC_LENGTH-2];
          end
        end
      end
      S_LOW: begin
        if (hcnt_last) begin
          if (bits_q != '0) begin
            state_d = S_HIGH;
            sclk_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            fcs_d   = 1'b0;
            pcs_d   = 1'b0;
            sdata_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (hcnt_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bits_q  <= '0;
      sreg_q  <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      fcs_q   <= 1'b0;
      pcs_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bits_q  <= bits_d;
      sreg_q  <= sreg_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      fcs_q   <= fcs_d;
      pcs_q   <= pcs_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready     = ready_q;
  assign busy          = ~ready_q;
  assign done          = done_q;
  assign spi_clk       = sclk_q;
  assign spi_data      = sdata_q;
  assign freq_cs       = fcs_q;
  assign phaseshift_cs = pcs_q;
  assign dbg_state_o   = state_q;

endmodule
